// File: rtl/ysyx_25070198_ifu_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ysyx_25070198_ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DROP = 2'd3
   } ifu_state_t;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25070198_ifq_fifo.sv
// DEPTH-entry circular buffer with push/pop/flush; DEPTH must be a power of two.
module ysyx_25070198_ifq_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ysyx_25070198_ifq.sv
// Instruction fetch unit with prefetch queue and redirect flush.
// Optional perf counters enabled by defining YSYX_IFQ_PERF_EN.
module ysyx_25070198_ifq
   import ysyx_25070198_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [XLEN-1:0]            mem_req_addr,
   input  logic                       mem_resp_valid,
   input  logic [XLEN-1:0]            mem_resp_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_inst,
`ifdef YSYX_IFQ_PERF_EN
   output logic [31:0]                perf_fetch_cnt,
   output logic [31:0]                perf_stall_cnt,
`endif
   output logic [$clog2(DEPTH+1)-1:0] q_count
);

   localparam int unsigned       CW   = $clog2(DEPTH+1);
   localparam logic [CW-1:0]     FULL = CW'(DEPTH);

   ifu_state_t        state;
   logic [XLEN-1:0]   fetch_pc;
   logic              push;
   logic              pop;
   logic [CW-1:0]     count_next;
   logic [2*XLEN-1:0] head_data;
   logic              unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   assign push       = (state == WAIT) && mem_resp_valid && !redirect_valid;
   assign pop        = out_valid && out_ready && !redirect_valid;
   assign count_next = q_count + CW'(push) - CW'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         // An accepted request whose response is still to come must be swallowed.
         case (state)
            REQ:     state <= mem_req_ready ? DROP : REQ;
            WAIT:    state <= mem_resp_valid ? REQ : DROP;
            DROP:    state <= DROP;
            default: state <= REQ;
         endcase
      end else begin
         case (state)
            IDLE: if (q_count < FULL) state <= REQ;
            REQ:  if (mem_req_ready) state <= WAIT;
            WAIT: begin
               if (mem_resp_valid) begin
                  fetch_pc <= fetch_pc + XLEN'(4);
                  state    <= (count_next < FULL) ? REQ : IDLE;
               end
            end
            DROP:    if (mem_resp_valid) state <= REQ;
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_req_valid = (state == REQ);
   assign mem_req_addr  = fetch_pc;
   assign out_valid     = (q_count != '0);
   assign out_pc        = head_data[2*XLEN-1:XLEN];
   assign out_inst      = head_data[XLEN-1:0];

   ysyx_25070198_ifq_fifo #(
      .WIDTH(2*XLEN),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .push     (push),
      .push_data({fetch_pc, mem_resp_data}),
      .pop      (pop),
      .head_data(head_data),
      .count    (q_count)
   );

`ifdef YSYX_IFQ_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (push)                    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (out_ready && !out_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_25070198_ifq.sv
// Directed self-checking bench for ysyx_25070198_ifq (DEPTH=4, XLEN=32).
module tb_ysyx_25070198_ifq;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              redirect_valid = 1'b0;
   logic [XLEN-1:0]   redirect_pc = '0;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic [XLEN-1:0]   mem_req_addr;
   logic              mem_resp_valid;
   logic [XLEN-1:0]   mem_resp_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_inst;
   logic [2:0]        q_count;
`ifdef YSYX_IFQ_PERF_EN
   logic [31:0]       perf_fetch_cnt;
   logic [31:0]       perf_stall_cnt;
`endif

   // Memory stand-in: auto responder plus manual override.
   logic              auto_mem = 1'b0;
   logic              auto_resp = 1'b0;
   logic [XLEN-1:0]   auto_data = '0;
   logic              man_resp = 1'b0;
   logic [XLEN-1:0]   man_data = '0;
   int                req_cnt = 0;
   int                checks = 0;
   int                errors = 0;

   assign mem_resp_valid = auto_resp | man_resp;
   assign mem_resp_data  = auto_resp ? auto_data : man_data;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h8000_0000: rom = 32'h0000_0013;
         32'h8000_0004: rom = 32'h0010_0093;
         default:       rom = a ^ 32'h5A00_0000;
      endcase
   endfunction

   always @(posedge clk) begin
      if (auto_mem && mem_req_valid && mem_req_ready) begin
         auto_resp <= 1'b1;
         auto_data <= rom(mem_req_addr);
      end else begin
         auto_resp <= 1'b0;
      end
      if (mem_req_valid && mem_req_ready) req_cnt <= req_cnt + 1;
   end

   ysyx_25070198_ifq #(
      .XLEN (XLEN),
      .DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_inst      (out_inst),
`ifdef YSYX_IFQ_PERF_EN
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt),
`endif
      .q_count       (q_count)
   );

   // Holds reset for two cycles and releases it at a falling edge.
   task automatic do_reset();
      rst = 1'b1;
      auto_mem = 1'b0;
      man_resp = 1'b0;
      mem_req_ready = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", mem_req_valid); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_q_count got %0d want 0", q_count); end
      checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rst_addr got %h want 80000000", mem_req_addr); end
   endtask

   task automatic test_first_fetch();
      do_reset();
      mem_req_ready = 1'b1;
      auto_mem = 1'b1;
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL first_req_addr got %h want 80000000", mem_req_addr); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_out_valid got %b want 0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat3_out_valid got %b want 1", out_valid); end
      checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL first_pc got %h want 80000000", out_pc); end
      checks++; if (out_inst !== 32'h0000_0013) begin errors++; $display("FAIL first_inst got %h want 00000013", out_inst); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL pop_q_count got %0d want 0", q_count); end
      @(negedge clk);
      checks++; if (out_pc !== 32'h8000_0004) begin errors++; $display("FAIL second_pc got %h want 80000004", out_pc); end
      checks++; if (out_inst !== 32'h0010_0093) begin errors++; $display("FAIL second_inst got %h want 00100093", out_inst); end
   endtask

   task automatic test_full();
      int base;
      do_reset();
      base = req_cnt;
      mem_req_ready = 1'b1;
      auto_mem = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (req_cnt - base !== 4) begin errors++; $display("FAIL full_req_cnt got %0d want 4", req_cnt - base); end
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL full_q_count got %0d want 4", q_count); end
      repeat (5) @(negedge clk);
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid got %b want 0", mem_req_valid); end
      checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL full_head_pc got %h want 80000000", out_pc); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (q_count !== 3'd3) begin errors++; $display("FAIL full_pop_cnt got %0d want 3", q_count); end
      checks++; if (out_pc !== 32'h8000_0004) begin errors++; $display("FAIL full_next_pc got %h want 80000004", out_pc); end
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL refill_valid got %b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h8000_0010) begin errors++; $display("FAIL refill_addr got %h want 80000010", mem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      mem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      man_resp = 1'b1;
      man_data = 32'h0000_0013;
      @(negedge clk);
      man_resp = 1'b0;
      @(negedge clk);
      checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL rw_pre_cnt got %0d want 1", q_count); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rw_flush_cnt got %0d want 0", q_count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rw_out_valid got %b want 0", out_valid); end
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_valid got %b want 0", mem_req_valid); end
      @(negedge clk);
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_hold got %b want 0", mem_req_valid); end
      man_resp = 1'b1;
      man_data = 32'hDEAD_BEEF;
      @(negedge clk);
      man_resp = 1'b0;
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rw_stale_cnt got %0d want 0", q_count); end
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rw_req_valid got %b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL rw_req_addr got %h want 80000100", mem_req_addr); end
   endtask

   task automatic test_redirect_resp();
      do_reset();
      mem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      man_resp = 1'b1;
      man_data = 32'h0000_0013;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0203;
      @(negedge clk);
      man_resp = 1'b0;
      redirect_valid = 1'b0;
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rr_q_count got %0d want 0", q_count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_out_valid got %b want 0", out_valid); end
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL rr_req_valid got %b want 1", mem_req_valid); end
      checks++; if (mem_req_addr !== 32'h8000_0200) begin errors++; $display("FAIL rr_req_addr got %h want 80000200", mem_req_addr); end
   endtask

   task automatic test_async_reset();
      do_reset();
      mem_req_ready = 1'b1;
      auto_mem = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL ar_pre_cnt got %0d want 1", q_count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_req_valid got %b want 0", mem_req_valid); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %b want 0", out_valid); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL ar_q_count got %0d want 0", q_count); end
      checks++; if (mem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL ar_addr got %h want 80000000", mem_req_addr); end
`ifdef YSYX_IFQ_PERF_EN
      checks++; if (perf_fetch_cnt !== 32'd0) begin errors++; $display("FAIL ar_perf_fetch got %0d want 0", perf_fetch_cnt); end
`endif
   endtask

`ifdef YSYX_IFQ_PERF_EN
   // Pushes land on edges 3,5,...; the sixth fetch is flushed by a coincident redirect.
   task automatic test_perf();
      do_reset();
      mem_req_ready = 1'b1;
      auto_mem = 1'b1;
      out_ready = 1'b1;
      repeat (12) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      repeat (8) @(negedge clk);
      checks++; if (perf_fetch_cnt !== 32'd9) begin errors++; $display("FAIL perf_fetch got %0d want 9", perf_fetch_cnt); end
      checks++; if (perf_stall_cnt !== 32'd13) begin errors++; $display("FAIL perf_stall got %0d want 13", perf_stall_cnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_fetch();
      test_full();
      test_redirect_wait();
      test_redirect_resp();
`ifdef YSYX_IFQ_PERF_EN
      test_perf();
`endif
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
